kanagawa_sim_ready_valid_to_mailbox: RTL and testbench



---
 rtl/kanagawa_sim_ready_valid_to_mailbox.sv | 164 ++++++++++++++++
 tb/tb_kanagawa_sim_ready_valid_to_mailbox.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_sim_ready_valid_to_mailbox.sv
// rtl/kanagawa_sim_ready_valid_to_mailbox.sv - ready/valid sink that queues accepted items for the bench
// Registered backpressure with policy-driven stalls, plus a producer protocol checker.

module kanagawa_sim_staller #(
  parameter int POLICY = 0,
  parameter int SEED   = 0
) (
  input  logic clk,
  input  logic rst,
  output logic stalled_out
);
  // POLICY 0 never stalls; POLICY 1 stalls pseudo-randomly about one cycle in four.
  localparam logic [15:0] SEED_VAL = (SEED == 0) ? 16'hACE1 : 16'(SEED);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED_VAL;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stalled_out = (POLICY == 1) && (lfsr[1:0] == 2'b00);
endmodule

module kanagawa_sim_ready_valid_to_mailbox #(
  parameter type T                  = logic,
  parameter int  DEPTH              = 0,
  parameter bit  CLEAR_ON_RESET     = 1'b1,
  parameter int  STALL_POLICY       = 0,
  parameter int  STALLER_SEED       = 0,
  parameter int  COUNT_WIDTH        = 32,
  parameter int  UNBOUNDED_CAPACITY = 4096,
  parameter bit  REPORT_ERRORS      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [$bits(T)-1:0]    data_in,
  output logic                   ready_out,
  output logic [COUNT_WIDTH-1:0] accepted_count_out,
  output logic                   protocol_error_out
);
  localparam int          W       = $bits(T);
  localparam int          STORE   = (DEPTH == 0) ? UNBOUNDED_CAPACITY : DEPTH;
  localparam int          AW      = (STORE > 1) ? $clog2(STORE) : 1;
  localparam int unsigned STORE_U = STORE;
  localparam int unsigned DEPTH_U = DEPTH;

  // Free-running pointers: the clocked logic owns wr_ptr, the user API owns rd_ptr.
  int unsigned            wr_ptr;
  int unsigned            rd_ptr;
  logic [W-1:0]           mem [STORE];
  logic                   ready_ff;
  logic                   stall;
  logic                   push;
  logic                   pending;
  logic [W-1:0]           pending_data;
  logic                   violation;
  logic [COUNT_WIDTH-1:0] accepted_count;
  int                     protocol_error_count;

  kanagawa_sim_staller #(
    .POLICY (STALL_POLICY),
    .SEED   (STALLER_SEED)
  ) u_staller (
    .clk         (clk),
    .rst         (!rst_n),
    .stalled_out (stall)
  );

  assign push      = valid_in && ready_ff;
  assign violation = pending && (!valid_in || (data_in !== pending_data));

  function automatic logic [AW-1:0] slot(input int unsigned p);
    return AW'(p % STORE_U);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_ff             <= 1'b0;
      pending              <= 1'b0;
      pending_data         <= '0;
      protocol_error_out   <= 1'b0;
      accepted_count       <= '0;
      protocol_error_count <= 0;
      // Catching the write pointer up to the reader discards everything queued.
      if (CLEAR_ON_RESET) begin
        wr_ptr <= rd_ptr;
      end
    end else begin
      // Occupancy seen here already includes this edge's push and earlier pops.
      ready_ff <= !stall && ((DEPTH == 0) || ((wr_ptr + 32'(push) - rd_ptr) < DEPTH_U));
      if (push) begin
        wr_ptr         <= wr_ptr + 1;
        accepted_count <= accepted_count + COUNT_WIDTH'(1);
      end
      protocol_error_out <= violation;
      if (violation) begin
        protocol_error_count <= protocol_error_count + 1;
      end
      pending <= valid_in && !ready_ff;
      if (valid_in && !ready_ff) begin
        pending_data <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      assert ((wr_ptr - rd_ptr) < STORE_U)
        else $error("mailbox put failed: storage exhausted");
      mem[slot(wr_ptr)] <= data_in;
    end
    if (rst_n && REPORT_ERRORS) begin
      if (violation) begin
        $error("ready/valid protocol violation: item withdrawn or changed while stalled");
      end
      if (valid_in && $isunknown(data_in)) begin
        $error("unknown bits on data_in while valid_in is high");
      end
    end
  end

  assign ready_out          = ready_ff;
  assign accepted_count_out = accepted_count;

  function automatic int num();
    return int'(wr_ptr - rd_ptr);
  endfunction

  function automatic bit try_peek(output T item);
    item = T'(mem[slot(rd_ptr)]);
    return wr_ptr != rd_ptr;
  endfunction

  function automatic bit try_get(output T item);
    item = T'(mem[slot(rd_ptr)]);
    if (wr_ptr == rd_ptr) begin
      return 1'b0;
    end
    rd_ptr = rd_ptr + 1;
    return 1'b1;
  endfunction

  task automatic get(output T item);
    while (wr_ptr == rd_ptr) @(wr_ptr);
    void'(try_get(item));
  endtask

  function automatic void clear();
    rd_ptr = wr_ptr;
  endfunction

  function automatic int errors();
    return protocol_error_count;
  endfunction

  task automatic wait_for(input int n);
    while (int'(accepted_count) < n) @(accepted_count);
  endtask
endmodule

// File: tb/tb_kanagawa_sim_ready_valid_to_mailbox.sv
// tb/tb_kanagawa_sim_ready_valid_to_mailbox.sv - self-checking bench for the ready/valid-to-mailbox sink
// Four sink instances cover unbounded, DEPTH=2, random-stall and 4-bit-counter configurations.

module tb_kanagawa_sim_ready_valid_to_mailbox;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [4];
  logic        vld  [4];
  logic [7:0]  dat  [4];
  logic        rdy  [4];
  logic        perr [4];
  logic [31:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  int errors = 0;
  int checks = 0;

  // Expected state, derived from the sink's rules: occupancy, items accepted, ready, error pulse.
  int         m_occ   [4];
  int         m_cnt   [4];
  bit         m_ready [4];
  bit         m_pend  [4];
  bit         m_err   [4];
  logic [7:0] m_pdata [4];

  kanagawa_sim_ready_valid_to_mailbox #(.T(logic [7:0]), .DEPTH(0)) u0 (
    .clk(clk), .rst_n(rstn[0]), .valid_in(vld[0]), .data_in(dat[0]),
    .ready_out(rdy[0]), .accepted_count_out(cnt0), .protocol_error_out(perr[0]));

  kanagawa_sim_ready_valid_to_mailbox #(.T(logic [7:0]), .DEPTH(2), .REPORT_ERRORS(1'b0)) u1 (
    .clk(clk), .rst_n(rstn[1]), .valid_in(vld[1]), .data_in(dat[1]),
    .ready_out(rdy[1]), .accepted_count_out(cnt1), .protocol_error_out(perr[1]));

  kanagawa_sim_ready_valid_to_mailbox #(.T(logic [7:0]), .DEPTH(0), .STALL_POLICY(1), .STALLER_SEED(1234)) u2 (
    .clk(clk), .rst_n(rstn[2]), .valid_in(vld[2]), .data_in(dat[2]),
    .ready_out(rdy[2]), .accepted_count_out(cnt2), .protocol_error_out(perr[2]));

  kanagawa_sim_ready_valid_to_mailbox #(.T(logic [7:0]), .DEPTH(0), .COUNT_WIDTH(4)) u3 (
    .clk(clk), .rst_n(rstn[3]), .valid_in(vld[3]), .data_in(dat[3]),
    .ready_out(rdy[3]), .accepted_count_out(cnt3), .protocol_error_out(perr[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic logic [31:0] cnt_of(input int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      default: return {28'd0, cnt3};
    endcase
  endfunction

  function automatic void model_reset(input int k);
    m_occ[k]   = 0;
    m_cnt[k]   = 0;
    m_ready[k] = 1'b0;
    m_pend[k]  = 1'b0;
    m_err[k]   = 1'b0;
    m_pdata[k] = '0;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      if (!rstn[k]) begin
        model_reset(k);
      end else begin
        if (vld[k] && m_ready[k]) begin
          m_occ[k]++;
          m_cnt[k]++;
        end
        m_err[k]   = m_pend[k] && (!vld[k] || dat[k] != m_pdata[k]);
        m_pend[k]  = vld[k] && !m_ready[k];
        m_pdata[k] = dat[k];
        m_ready[k] = (depth_of(k) == 0) || (m_occ[k] < depth_of(k));
      end
    end
  endtask

  // The random-stall instance is checked end-to-end rather than cycle by cycle.
  task automatic compare();
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        logic [31:0] ec;
        ec = (k == 3) ? 32'(m_cnt[k] % 16) : 32'(m_cnt[k]);
        check($sformatf("cyc_ready_u%0d", k), rdy[k], m_ready[k]);
        check($sformatf("cyc_count_u%0d", k), cnt_of(k), ec);
        check($sformatf("cyc_perr_u%0d", k), perr[k], m_err[k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int k, input logic [7:0] d);
    bit r;
    int n;
    n = 0;
    vld[k] = 1'b1;
    dat[k] = d;
    do begin
      r = rdy[k];
      tick();
      n++;
    end while (!r && n < 200);
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL send_timeout_u%0d: not accepted after %0d cycles, required accept", k, n);
    end
    vld[k] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at 1ms, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] sent [$];
    bit         ok;

    for (int k = 0; k < 4; k++) begin
      rstn[k] = 1'b0;
      vld[k]  = 1'b0;
      dat[k]  = '0;
      model_reset(k);
    end
    repeat (3) tick();
    check("reset_ready_u0", rdy[0], 0);
    check("reset_count_u0", cnt0, 0);
    check("reset_perr_u1", perr[1], 0);
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;
    check("ready_before_first_edge_u0", rdy[0], 0);
    tick();
    check("ready_after_first_edge_u0", rdy[0], 1);
    check("ready_after_first_edge_u1", rdy[1], 1);

    // Unbounded sink, 100 back-to-back items.
    for (int i = 0; i < 100; i++) send(0, 8'(i));
    check("a_count", cnt0, 100);
    check("a_num", u0.num(), 100);
    ok = u0.try_peek(v);
    check("a_peek", {7'd0, ok, v}, {8'd1, 8'd0});
    for (int i = 0; i < 100; i++) begin
      ok = u0.try_get(v);
      if (ok) m_occ[0]--;
      check("a_item", {7'd0, ok, v}, {8'd1, 8'(i)});
    end

    // DEPTH=2: A and B fill the sink, C waits for a pop.
    send(1, 8'hA1);
    send(1, 8'hB2);
    vld[1] = 1'b1;
    dat[1] = 8'hC3;
    tick();
    check("b_ready_full", rdy[1], 0);
    check("b_count_full", cnt1, 2);
    check("b_num_full", u1.num(), 2);
    u1.get(v);
    m_occ[1]--;
    check("b_get_a", v, 8'hA1);
    tick();
    check("b_ready_back", rdy[1], 1);
    check("b_count_before_c", cnt1, 2);
    tick();
    check("b_count_c", cnt1, 3);
    check("b_ready_full_again", rdy[1], 0);

    // Protocol violations while stalled: data change 5->6, then a dropped valid.
    dat[1] = 8'd5;
    tick();
    check("c_no_err_hold", perr[1], 0);
    dat[1] = 8'd6;
    tick();
    check("c_perr_change", perr[1], 1);
    check("c_errors_1", u1.errors(), 1);
    ok = u1.try_get(v);
    if (ok) m_occ[1]--;
    check("c_get_b", {7'd0, ok, v}, {8'd1, 8'hB2});
    tick();
    check("c_perr_single", perr[1], 0);
    check("c_ready_after_pop", rdy[1], 1);
    tick();
    check("c_count_6", cnt1, 4);
    check("c_errors_still_1", u1.errors(), 1);
    dat[1] = 8'd7;
    tick();
    vld[1] = 1'b0;
    tick();
    check("c_perr_drop", perr[1], 1);
    check("c_errors_2", u1.errors(), 2);
    tick();
    check("c_perr_clear", perr[1], 0);
    ok = u1.try_get(v);
    if (ok) m_occ[1]--;
    check("c_get_c", {7'd0, ok, v}, {8'd1, 8'hC3});
    ok = u1.try_get(v);
    if (ok) m_occ[1]--;
    check("c_get_6", {7'd0, ok, v}, {8'd1, 8'd6});
    ok = u1.try_get(v);
    check("c_empty", ok, 0);

    // Random backpressure: 1000 items must arrive intact and in order.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      sent.push_back(d);
      send(2, d);
      if ($urandom_range(0, 3) == 0) tick();
    end
    check("d_count", cnt2, 1000);
    check("d_num", u2.num(), 1000);
    check("d_errors", u2.errors(), 0);
    for (int i = 0; i < 1000; i++) begin
      ok = u2.try_get(v);
      check("d_item", {7'd0, ok, v}, {8'd1, sent[i]});
    end

    // Asynchronous reset mid-stream empties the mailbox and clears the counter.
    for (int i = 0; i < 10; i++) send(0, 8'(100 + i));
    check("e_num_before", u0.num(), 10);
    check("e_count_before", cnt0, 110);
    vld[0] = 1'b1;
    dat[0] = 8'd200;
    #2;
    rstn[0] = 1'b0;
    model_reset(0);
    #1;
    check("e_async_ready", rdy[0], 0);
    check("e_async_count", cnt0, 0);
    check("e_async_num", u0.num(), 0);
    tick();
    tick();
    check("e_no_accept_in_reset", cnt0, 0);
    vld[0]  = 1'b0;
    rstn[0] = 1'b1;
    tick();
    send(0, 8'd11);
    send(0, 8'd12);
    check("e_count_after", cnt0, 2);
    check("e_num_after", u0.num(), 2);
    ok = u0.try_get(v);
    if (ok) m_occ[0]--;
    check("e_item_11", {7'd0, ok, v}, {8'd1, 8'd11});
    ok = u0.try_get(v);
    if (ok) m_occ[0]--;
    check("e_item_12", {7'd0, ok, v}, {8'd1, 8'd12});

    // 4-bit counter wraps after 16; storage keeps all 17 items.
    for (int i = 0; i < 17; i++) send(3, 8'(i * 3));
    check("f_count_wrap", cnt3, 1);
    check("f_num", u3.num(), 17);
    for (int i = 0; i < 17; i++) begin
      ok = u3.try_get(v);
      if (ok) m_occ[3]--;
      check("f_item", {7'd0, ok, v}, {8'd1, 8'(i * 3)});
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
